boot_sequencer: RTL and testbench
=================================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter: SETTLE_CYCLES, 3, number of cycles between the last ROM write and CPU reset release (must be >= 1).
REQ-002 Parameter: TIMEOUT_CYCLES, 1024, maximum number of consecutive LOAD cycles without an accepted word before the load aborts.
REQ-003 Port: clock  in  1  sole clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  asynchronous, active-high; forces all state and outputs to reset values immediately.
REQ-005 Port: start  in  1  one-cycle request to begin a boot load.
REQ-006 Port: word_count  in  8  number of instruction words to load (0..255), sampled with start.
REQ-007 Port: in_valid  in  1  in_data holds a valid instruction word.
REQ-008 Port: in_data  in  16  instruction word.
REQ-009 Port: in_ready  out  1  sequencer accepts in_data this cycle.
REQ-010 Port: rom_sel  out  1  high selects the bootloader address/data path into instruction ROM.
REQ-011 Port: rom_we  out  1  instruction ROM write strobe.
REQ-012 Port: rom_addr  out  8  instruction ROM write address.
REQ-013 Port: rom_din  out  16  instruction ROM write data.
REQ-014 Port: cpu_reset  out  1  reset to CPU core; high holds the core in reset.
REQ-015 Port: busy  out  1  high in LOAD or SETTLE.
REQ-016 Port: done  out  1  high in RUN.
REQ-017 Port: error  out  1  high in ABORT.

Function
REQ-018 States IDLE, LOAD, SETTLE, RUN, ABORT; all outputs except in_ready are registered; in_ready = (state==LOAD) combinationally.
REQ-019 IDLE: start=1 latches word_count, clears the write index and stall counter; next state LOAD if word_count!=0, otherwise SETTLE.
REQ-020 LOAD: a word is accepted on each edge where in_valid && in_ready; accepted words produce rom_we=1, rom_addr=index, rom_din=in_data during the following cycle (1-cycle write latency), and the index increments by 1.
REQ-021 Addresses are contiguous from 0 regardless of in_valid gaps; no rom_we while no word is accepted.
REQ-022 Acceptance of word number word_count moves the state to SETTLE on the same edge; its write occurs in the first SETTLE cycle.
REQ-023 rom_sel = 1 during LOAD and in any cycle where rom_we=1; otherwise 0.
REQ-024 SETTLE: lasts exactly SETTLE_CYCLES cycles, then RUN; rom_sel=0 after the final write; cpu_reset stays 1.
REQ-025 cpu_reset = 0 only in RUN; done = 1 only in RUN.
REQ-026 Stall counter increments on every LOAD cycle without acceptance and clears on acceptance; reaching TIMEOUT_CYCLES moves to ABORT: rom_we=0, rom_sel=0, cpu_reset=1, error=1.
REQ-027 start is ignored in LOAD and SETTLE.
REQ-028 start in RUN or ABORT behaves as in IDLE (REQ-019): cpu_reset=1 and done=0 from the next cycle, error cleared, and the ROM is reloaded from address 0.
REQ-029 Simultaneous acceptance of the last word and a timeout-count match: acceptance wins and the state moves to SETTLE.

Reset
REQ-030 On reset=1: state IDLE, cpu_reset=1, rom_sel=0, rom_we=0, rom_addr=0, rom_din=0, in_ready=0, busy=0, done=0, error=0, index=0, counters=0.
REQ-031 reset asserted mid-LOAD or mid-SETTLE aborts immediately; no partial write strobe is issued after reset assertion.

Verification
REQ-032 Reset, start with word_count=10, in_valid held high with in_data=0x1121 -> 10 consecutive rom_we pulses at addresses 0x00..0x09 with data 0x1121, rom_sel falls after the 10th write, cpu_reset falls 3 cycles later, done=1.
REQ-033 start with word_count=0 -> no rom_we; SETTLE lasts 3 cycles; cpu_reset=0 and done=1 on the 4th cycle after start.
REQ-034 word_count=4 with in_valid toggling 1,0,0,1,1,0,1 -> exactly 4 writes at addresses 0..3 in accept order; busy is high throughout.
REQ-035 word_count=4, 2 words supplied, then in_valid=0 -> error=1 after 1024 idle cycles, cpu_reset=1, rom_sel=0; a new start clears error and the next write goes to address 0.
REQ-036 reset pulsed while the 3rd of 5 words is being loaded -> all outputs take reset values in the same cycle, and no further rom_we is issued.
REQ-037 start pulsed in RUN -> cpu_reset=1 the next cycle, followed by a full reload and release.

Source files
------------

// File: rtl/boot_sequencer.sv
//------------------------------------------------------------------------------
// boot_sequencer
// Streams a block of instruction words into the instruction ROM, waits a short
// settle period, then releases the CPU core from reset.
//
// Parameters
//   SETTLE_CYCLES  : cycles from the last ROM write cycle to CPU reset release (>= 1)
//   TIMEOUT_CYCLES : consecutive LOAD cycles without an accepted word before abort
//
// Ports
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   start, word_count   : boot request and number of words to load (0..255)
//   in_valid, in_data   : incoming instruction word stream
//   in_ready            : word accepted this cycle (combinational, high in LOAD)
//   rom_sel             : bootloader owns the ROM address/data path
//   rom_we/addr/din     : ROM write port, one cycle after acceptance
//   cpu_reset           : holds the CPU core in reset (low only in RUN)
//   busy, done, error   : LOAD/SETTLE, RUN and ABORT indicators
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module boot_sequencer #(
   parameter int unsigned SETTLE_CYCLES  = 3,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  word_count,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   output logic        in_ready,
   output logic        rom_sel,
   output logic        rom_we,
   output logic [7:0]  rom_addr,
   output logic [15:0] rom_din,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic        error
);

   localparam int unsigned ADDR_W   = 8;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned STALL_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      RUN    = 3'd3,
      ABORT  = 3'd4
   } state_t;

   state_t              state, stateNext;
   logic [ADDR_W-1:0]   index, indexNext;
   logic [ADDR_W-1:0]   total, totalNext;
   logic [STALL_W-1:0]  stall, stallNext;
   logic [SETTLE_W-1:0] settleCnt, settleNext;
   logic                accept;

   logic                romSelNext, romWeNext, cpuResetNext;
   logic                busyNext, doneNext, errorNext;
   logic [ADDR_W-1:0]   romAddrNext;
   logic [DATA_W-1:0]   romDinNext;

   assign in_ready = (state == LOAD);

   // Next-state, counter and registered-output computation
   always_comb begin
      stateNext   = state;
      indexNext   = index;
      totalNext   = total;
      stallNext   = stall;
      settleNext  = settleCnt;
      accept      = 1'b0;
      romAddrNext = rom_addr;
      romDinNext  = rom_din;

      case (state)
         IDLE, RUN, ABORT: begin
            if (start) begin
               totalNext  = word_count;
               indexNext  = '0;
               stallNext  = '0;
               settleNext = '0;
               stateNext  = (word_count != 8'd0) ? LOAD : SETTLE;
            end
         end
         LOAD: begin
            if (in_valid && in_ready) begin
               // Acceptance takes priority over a coincident timeout
               accept      = 1'b1;
               romAddrNext = index;
               romDinNext  = in_data;
               indexNext   = index + ADDR_W'(1);
               stallNext   = '0;
               if (index == total - ADDR_W'(1)) begin
                  stateNext  = SETTLE;
                  settleNext = '0;
               end
            end else if (stall == STALL_W'(TIMEOUT_CYCLES - 1)) begin
               stateNext = ABORT;
            end else begin
               stallNext = stall + STALL_W'(1);
            end
         end
         SETTLE: begin
            if (settleCnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
               stateNext = RUN;
            end else begin
               settleNext = settleCnt + SETTLE_W'(1);
            end
         end
         default: stateNext = IDLE;
      endcase

      // Outputs are registered, so they track the state being entered
      romWeNext    = accept;
      romSelNext   = (stateNext == LOAD) || accept;
      cpuResetNext = (stateNext != RUN);
      busyNext     = (stateNext == LOAD) || (stateNext == SETTLE);
      doneNext     = (stateNext == RUN);
      errorNext    = (stateNext == ABORT);
   end

   // State, counters and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         index     <= '0;
         total     <= '0;
         stall     <= '0;
         settleCnt <= '0;
         rom_sel   <= 1'b0;
         rom_we    <= 1'b0;
         rom_addr  <= '0;
         rom_din   <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= stateNext;
         index     <= indexNext;
         total     <= totalNext;
         stall     <= stallNext;
         settleCnt <= settleNext;
         rom_sel   <= romSelNext;
         rom_we    <= romWeNext;
         rom_addr  <= romAddrNext;
         rom_din   <= romDinNext;
         cpu_reset <= cpuResetNext;
         busy      <= busyNext;
         done      <= doneNext;
         error     <= errorNext;
      end
   end

endmodule

// File: tb/tb_boot_sequencer.sv
//------------------------------------------------------------------------------
// tb_boot_sequencer
// Self-checking bench: a directed vector table, hand-written corner sequences
// (timeout, acceptance racing the timeout, reset mid-load) and random boot
// sessions checked cycle by cycle against a count-based reference model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_boot_sequencer;

   localparam int SETTLE  = 3;
   localparam int TIMEOUT = 1024;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  word_count;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_ready;
   logic        rom_sel;
   logic        rom_we;
   logic [7:0]  rom_addr;
   logic [15:0] rom_din;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        error;

   int checks = 0;
   int errors = 0;

   boot_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .word_count(word_count),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .rom_sel   (rom_sel),
      .rom_we    (rom_we),
      .rom_addr  (rom_addr),
      .rom_din   (rom_din),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        start;
      logic [7:0]  wc;
      logic        valid;
      logic [15:0] data;
      logic        we;
      logic        sel;
      logic        cpuRst;
      logic        bsy;
      logic        dn;
      logic        err;
      logic        rdy;
      logic [7:0]  addr;
      logic [15:0] din;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic checkOutputs(input string tag, input logic we, input logic sel,
                               input logic cR, input logic bz, input logic dn,
                               input logic er, input logic rdy,
                               input logic [7:0] addr, input logic [15:0] din);
      chk({tag, "_rom_we"},    32'(rom_we),    32'(we));
      chk({tag, "_rom_sel"},   32'(rom_sel),   32'(sel));
      chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(cR));
      chk({tag, "_busy"},      32'(busy),      32'(bz));
      chk({tag, "_done"},      32'(done),      32'(dn));
      chk({tag, "_error"},     32'(error),     32'(er));
      chk({tag, "_in_ready"},  32'(in_ready),  32'(rdy));
      if (we) begin
         chk({tag, "_rom_addr"}, 32'(rom_addr), 32'(addr));
         chk({tag, "_rom_din"},  32'(rom_din),  32'(din));
      end
   endtask

   function automatic vec_t mk(input logic st, input logic [7:0] wc, input logic v,
                               input logic [15:0] d, input logic we, input logic sel,
                               input logic cR, input logic bz, input logic dn,
                               input logic er, input logic rdy,
                               input logic [7:0] a, input logic [15:0] di);
      vec_t r;
      r.start = st; r.wc = wc; r.valid = v; r.data = d;
      r.we = we; r.sel = sel; r.cpuRst = cR; r.bsy = bz; r.dn = dn; r.err = er;
      r.rdy = rdy; r.addr = a; r.din = di;
      return r;
   endfunction

   // One boot session, modelled by counting accepted words and settle cycles.
   // The valid pattern comes from pat (bit per LOAD cycle, then held high) or
   // from $urandom; random mode also pulses start while busy, which must be ignored.
   task automatic runSession(input int wc, input bit useRand, input logic [31:0] pat,
                             input logic [15:0] fixedData);
      int          accepted = 0;
      int          settleLeft;
      int          writes = 0;
      bit          loadPh;
      bit          pend = 1'b0;
      bit          newPend;
      bit          running = 1'b0;
      logic [7:0]  pAddr = 8'd0;
      logic [15:0] pData = 16'd0;
      logic        v;
      logic [15:0] d;

      start      = 1'b1;
      word_count = 8'(wc);
      in_valid   = 1'b0;
      step();
      start      = 1'b0;
      loadPh     = (wc != 0);
      settleLeft = loadPh ? 0 : SETTLE;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         running = !loadPh && (settleLeft == 0);
         checkOutputs($sformatf("sess_wc%0d_cyc%0d", wc, cyc), pend, loadPh || pend,
                      !running, !running, running, 1'b0, loadPh, pAddr, pData);
         if (rom_we === 1'b1) writes++;
         if (running) break;

         v = useRand ? logic'($urandom_range(0, 3) != 0) : ((cyc < 32) ? pat[cyc] : 1'b1);
         d = useRand ? 16'($urandom) : fixedData;
         in_valid = v;
         in_data  = d;
         if (useRand) begin
            start      = ($urandom_range(0, 7) == 0);
            word_count = 8'($urandom);
         end

         newPend = 1'b0;
         if (loadPh) begin
            if (v) begin
               newPend = 1'b1;
               pAddr   = 8'(accepted);
               pData   = d;
               accepted++;
               if (accepted == wc) begin
                  loadPh     = 1'b0;
                  settleLeft = SETTLE;
               end
            end
         end else begin
            settleLeft--;
         end
         pend = newPend;
         step();
      end

      chk($sformatf("sess_wc%0d_reached_run", wc), 32'(done), 32'd1);
      chk($sformatf("sess_wc%0d_write_count", wc), 32'(writes), 32'(wc));
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      vec_t tbl[12];
      int   n;

      reset      = 1'b1;
      start      = 1'b0;
      word_count = 8'd0;
      in_valid   = 1'b0;
      in_data    = 16'd0;

      // Reset values
      step();
      step();
      checkOutputs("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
      chk("reset_rom_addr", 32'(rom_addr), 32'd0);
      chk("reset_rom_din",  32'(rom_din),  32'd0);
      reset = 1'b0;
      step();

      // Directed table: zero-word boot, then two-word reload from RUN with
      // start pulses in LOAD and SETTLE that must be ignored
      //            st  wc    v  data        we sel cR bz dn er rdy addr  din
      tbl[0]  = mk(1, 8'd0, 0, 16'h0000,   0, 0, 1, 1, 0, 0, 0, 8'd0, 16'h0000);
      tbl[1]  = mk(0, 8'd0, 0, 16'h0000,   0, 0, 1, 1, 0, 0, 0, 8'd0, 16'h0000);
      tbl[2]  = mk(0, 8'd0, 0, 16'h0000,   0, 0, 1, 1, 0, 0, 0, 8'd0, 16'h0000);
      tbl[3]  = mk(0, 8'd0, 0, 16'h0000,   0, 0, 0, 0, 1, 0, 0, 8'd0, 16'h0000);
      tbl[4]  = mk(0, 8'd0, 0, 16'h0000,   0, 0, 0, 0, 1, 0, 0, 8'd0, 16'h0000);
      tbl[5]  = mk(1, 8'd2, 0, 16'h0000,   0, 1, 1, 1, 0, 0, 1, 8'd0, 16'h0000);
      tbl[6]  = mk(0, 8'd0, 1, 16'hBEEF,   1, 1, 1, 1, 0, 0, 1, 8'd0, 16'hBEEF);
      tbl[7]  = mk(0, 8'd0, 0, 16'h0000,   0, 1, 1, 1, 0, 0, 1, 8'd0, 16'h0000);
      tbl[8]  = mk(1, 8'd7, 1, 16'h0042,   1, 1, 1, 1, 0, 0, 0, 8'd1, 16'h0042);
      tbl[9]  = mk(0, 8'd0, 1, 16'hBEEF,   0, 0, 1, 1, 0, 0, 0, 8'd0, 16'h0000);
      tbl[10] = mk(1, 8'd0, 1, 16'hBEEF,   0, 0, 1, 1, 0, 0, 0, 8'd0, 16'h0000);
      tbl[11] = mk(0, 8'd0, 0, 16'h0000,   0, 0, 0, 0, 1, 0, 0, 8'd0, 16'h0000);
      for (int i = 0; i < 12; i++) begin
         start      = tbl[i].start;
         word_count = tbl[i].wc;
         in_valid   = tbl[i].valid;
         in_data    = tbl[i].data;
         step();
         checkOutputs($sformatf("vec%0d", i), tbl[i].we, tbl[i].sel, tbl[i].cpuRst,
                      tbl[i].bsy, tbl[i].dn, tbl[i].err, tbl[i].rdy, tbl[i].addr, tbl[i].din);
      end
      start    = 1'b0;
      in_valid = 1'b0;

      // Ten words back to back, restarted from RUN
      runSession(10, 1'b0, 32'hFFFF_FFFF, 16'h1121);
      // Gapped valid 1,0,0,1,1,0,1
      runSession(4, 1'b0, 32'h0000_0059, 16'hA5A5);
      runSession(0, 1'b0, 32'h0, 16'h0);
      runSession(255, 1'b0, 32'hFFFF_FFFF, 16'h7E57);

      // Timeout: two of four words, then silence
      start = 1'b1; word_count = 8'd4; step(); start = 1'b0;
      in_valid = 1'b1; in_data = 16'h1111; step();
      in_valid = 1'b1; in_data = 16'h2222; step();
      in_valid = 1'b0;
      n = 0;
      while (error !== 1'b1 && n < TIMEOUT + 100) begin
         step();
         n++;
      end
      chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
      checkOutputs("abort", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 16'd0);
      // Restart from ABORT: error clears and loading begins at address 0
      runSession(3, 1'b0, 32'hFFFF_FFFF, 16'h3C3C);

      // Last word accepted on the very cycle the stall count would expire
      start = 1'b1; word_count = 8'd1; step(); start = 1'b0;
      in_valid = 1'b0;
      repeat (TIMEOUT - 1) step();
      chk("race_error_before", 32'(error), 32'd0);
      in_valid = 1'b1; in_data = 16'h5A5A; step();
      in_valid = 1'b0;
      checkOutputs("race_write", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 16'h5A5A);
      repeat (SETTLE) step();
      checkOutputs("race_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 16'd0);

      // Reset asserted mid-cycle while the 3rd of 5 words is presented
      start = 1'b1; word_count = 8'd5; step(); start = 1'b0;
      in_valid = 1'b1; in_data = 16'hAAAA; step();
      in_valid = 1'b1; in_data = 16'hBBBB; step();
      in_valid = 1'b1; in_data = 16'hCCCC;
      chk("rst_pre_rom_we", 32'(rom_we), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutputs("rst_async", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 16'd0);
      chk("rst_async_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_async_rom_din",  32'(rom_din),  32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutputs($sformatf("rst_after%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      1'b0, 1'b0, 8'd0, 16'd0);
      end
      in_valid = 1'b0;
      runSession(5, 1'b0, 32'h0000_0015, 16'h0F0F);

      // Random sessions
      for (int s = 0; s < 20; s++) begin
         runSession(int'($urandom_range(0, 40)), 1'b1, 32'h0, 16'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
